// File: rtl/cnt_disp_pkg.sv
// Shared definitions for the counter display stage.
//   disp_state_e : conversion FSM states (IDLE -> SHIFT -> COMMIT -> IDLE)
//   SEG_*        : active-low glyphs, bit order {g,f,e,d,c,b,a}
//   dd_adjust    : one double-dabble nibble correction step
package cnt_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } disp_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // A BCD nibble of 5 or more would exceed 9 after the next doubling, so it
  // is pre-corrected by +3. The add is 4 bits wide; nothing carries out.
  function automatic logic [3:0] dd_adjust(input logic [3:0] i_nib);
    logic [3:0] w_res;
    if (i_nib >= 4'd5) begin
      w_res = i_nib + 4'd3;
    end else begin
      w_res = i_nib;
    end
    return w_res;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment glyph.
//   i_bcd : 4-bit BCD digit
//   o_seg : segments {g,f,e,d,c,b,a}, active-low; codes 10-15 show blank
module seg7_decode
  import cnt_disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Glyph lookup
  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/cnt_seg7_disp.sv
// Display stage behind the up/down counter: samples q, converts it to BCD
// with a sequential double-dabble engine and scans a common-anode display.
//   clk  : system clock (q changes on negedge, sampled here on posedge)
//   rst  : asynchronous active-high reset
//   q    : binary counter value, N bits
//   an   : digit enables, active-low, one digit low at a time
//   seg  : segments {g,f,e,d,c,b,a}, active-low
//   busy : high while a conversion is in flight
module cnt_seg7_disp
  import cnt_disp_pkg::*;
#(
  parameter int N        = 4,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      q,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              busy
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int SH_W   = BCD_W + N;
  localparam int ITER_W = $clog2(N + 1);
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (!(10 ** DIGITS > 2 ** N - 1)) begin : g_bad_digits
    $error("cnt_seg7_disp: DIGITS too small to show every value of q");
  end
  if (SCAN_DIV < 1) begin : g_bad_scan
    $error("cnt_seg7_disp: SCAN_DIV must be at least 1");
  end

  disp_state_e       r_state, w_state_nx;
  logic [SH_W-1:0]   r_shreg, w_shreg_nx, w_adj;
  logic [N-1:0]      r_last_q, w_last_q_nx;
  logic [ITER_W-1:0] r_iter, w_iter_nx;
  logic              r_busy, w_busy_nx;
  logic              r_valid, w_valid_nx;
  logic [BCD_W-1:0]  r_disp, w_disp_nx, w_disp_sel;
  logic [DIV_W-1:0]  r_div;
  logic [IDX_W-1:0]  r_idx;
  logic [DIGITS-1:0] r_an, w_an;
  logic [6:0]        r_seg, w_seg;
  logic [3:0]        w_nib;

  // Double-dabble correction of every BCD nibble before the shift
  always_comb begin
    w_adj = r_shreg;
    for (int d = 0; d < DIGITS; d++) begin
      w_adj[N+4*d +: 4] = dd_adjust(r_shreg[N+4*d +: 4]);
    end
  end

  // FSM next-state and conversion datapath
  always_comb begin
    w_state_nx  = r_state;
    w_shreg_nx  = r_shreg;
    w_last_q_nx = r_last_q;
    w_iter_nx   = r_iter;
    w_busy_nx   = r_busy;
    w_valid_nx  = r_valid;
    w_disp_nx   = r_disp;
    case (r_state)
      ST_IDLE: begin
        // valid=0 after reset forces a conversion even if q equals last_q
        if (!r_valid || (q != r_last_q)) begin
          w_shreg_nx  = {{BCD_W{1'b0}}, q};
          w_last_q_nx = q;
          w_iter_nx   = {ITER_W{1'b0}};
          w_busy_nx   = 1'b1;
          w_state_nx  = ST_SHIFT;
        end else begin
          w_state_nx  = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        w_shreg_nx = {w_adj[SH_W-2:0], 1'b0};
        w_iter_nx  = r_iter + ITER_W'(1);
        if (r_iter == ITER_W'(N - 1)) begin
          w_state_nx = ST_COMMIT;
        end else begin
          w_state_nx = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        // Only a completed conversion ever reaches the display register
        w_disp_nx  = r_shreg[SH_W-1 -: BCD_W];
        w_valid_nx = 1'b1;
        w_busy_nx  = 1'b0;
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_busy_nx  = 1'b0;
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // FSM and conversion registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_shreg  <= {SH_W{1'b0}};
      r_last_q <= {N{1'b0}};
      r_iter   <= {ITER_W{1'b0}};
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_disp   <= {BCD_W{1'b0}};
    end else begin
      r_state  <= w_state_nx;
      r_shreg  <= w_shreg_nx;
      r_last_q <= w_last_q_nx;
      r_iter   <= w_iter_nx;
      r_busy   <= w_busy_nx;
      r_valid  <= w_valid_nx;
      r_disp   <= w_disp_nx;
    end
  end

  // Scan selection: nibble idx of the display register and its anode
  always_comb begin
    w_disp_sel = r_disp >> {r_idx, 2'b00};
    w_nib      = w_disp_sel[3:0];
    w_an       = ~(DIGITS'(1) << r_idx);
  end

  seg7_decode u_dec (
    .i_bcd (w_nib),
    .o_seg (w_seg)
  );

  // Free-running scan divider/index and registered display pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= {DIV_W{1'b0}};
      r_idx <= {IDX_W{1'b0}};
      r_an  <= {DIGITS{1'b1}};
      r_seg <= SEG_BLANK;
    end else begin
      r_an  <= w_an;
      r_seg <= w_seg;
      if (r_div == DIV_W'(SCAN_DIV - 1)) begin
        r_div <= {DIV_W{1'b0}};
        if (r_idx == IDX_W'(DIGITS - 1)) begin
          r_idx <= {IDX_W{1'b0}};
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

  assign an   = r_an;
  assign seg  = r_seg;
  assign busy = r_busy;

endmodule

// File: tb/tb_cnt_seg7_disp.sv
module tb_cnt_seg7_disp;

  localparam int N  = 4;
  localparam int D  = 2;
  localparam int SD = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] q   = '0;
  logic [D-1:0] an;
  logic [6:0]   seg;
  logic         busy;

  int n_total = 0;
  int n_bad   = 0;

  cnt_seg7_disp #(.N(N), .DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk  (clk),
    .rst  (rst),
    .q    (q),
    .an   (an),
    .seg  (seg),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Glyph table straight from the segment definitions
  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'h7F;
    endcase
  endfunction

  // Decimal digit i of value v
  function automatic int digit_of(input int v, input int i);
    int t;
    t = v;
    for (int k = 0; k < i; k++) t = t / 10;
    return t % 10;
  endfunction

  // Reference model: edge count since reset, remaining busy edges,
  // the shown decimal value; outputs derived with plain arithmetic.
  int         m_k     = 0;
  int         m_conv  = 0;
  int         m_val   = 0;
  int         m_disp  = 0;
  logic [N-1:0] m_last = '0;
  logic       m_valid = 1'b0;
  logic [D-1:0] e_an  = '1;
  logic [6:0] e_seg   = 7'h7F;
  logic       e_busy  = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_k <= 0; m_conv <= 0; m_val <= 0; m_disp <= 0;
      m_last <= '0; m_valid <= 1'b0;
      e_an <= '1; e_seg <= 7'h7F; e_busy <= 1'b0;
    end else begin
      m_k   <= m_k + 1;
      e_an  <= ~(D'(1) << ((m_k / SD) % D));
      e_seg <= glyph(digit_of(m_disp, (m_k / SD) % D));
      if (m_conv > 0) begin
        m_conv <= m_conv - 1;
        if (m_conv == 1) begin
          m_disp  <= m_val;
          m_valid <= 1'b1;
          e_busy  <= 1'b0;
        end else begin
          e_busy  <= 1'b1;
        end
      end else if (!m_valid || q != m_last) begin
        m_conv <= N + 1;
        m_val  <= int'(q);
        m_last <= q;
        e_busy <= 1'b1;
      end else begin
        e_busy <= 1'b0;
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_val("an",   32'(an),   32'(e_an));
      check_val("seg",  32'(seg),  32'(e_seg));
      check_val("busy", 32'(busy), 32'(e_busy));
    end
  endtask

  // Direct constant check of the glyph shown on each digit over a full scan
  task automatic check_glyphs(input int d1, input int d0);
    for (int i = 0; i < 2 * SD; i++) begin
      step(1);
      if (an == 2'b10) check_val("digit0", 32'(seg), 32'(glyph(d0)));
      else if (an == 2'b01) check_val("digit1", 32'(seg), 32'(glyph(d1)));
      else check_val("an_onehot", 32'(an), 32'h2);
    end
  endtask

  initial begin
    // 1: reset state, first conversion of 0
    #1 rst = 1'b1;
    step(3);
    check_val("rst_an",   32'(an),   32'h3);
    check_val("rst_seg",  32'(seg),  32'h7F);
    check_val("rst_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    step(10);
    check_glyphs(0, 0);

    // 2: q = 9
    q = 4'd9;
    step(N + 2);
    check_glyphs(0, 9);

    // 3: q = 15, then scoreboard every value
    q = 4'd15;
    step(N + 2);
    check_glyphs(1, 5);
    for (int v = 0; v < 16; v++) begin
      q = N'(v);
      step(2 * (N + 2) + 2 * SD);
    end

    // 4: counter wraps 15 -> 0 two cycles into a conversion
    q = 4'd0;
    step(12);
    q = 4'd15;
    step(2);
    q = 4'd0;
    step(2 * (N + 2));
    check_glyphs(0, 0);

    // randomized q changes with random hold times
    for (int i = 0; i < 40; i++) begin
      q = N'($urandom_range(0, 15));
      step($urandom_range(1, 14));
    end
    step(12);

    // 6: async reset during SHIFT, then convert 7
    q = 4'd3;
    step(2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_an",   32'(an),   32'h3);
    check_val("arst_seg",  32'(seg),  32'h7F);
    check_val("arst_busy", 32'(busy), 32'h0);
    q = 4'd7;
    step(2);
    rst = 1'b0;
    step(12);
    check_glyphs(0, 7);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
